seg_display_sched: RTL and testbench
====================================

# seg_display_sched

Round-robin scheduler that time-shares the two-digit seven-segment display between up to `N_REQ` requesters. Each requester presents an 8-bit value (two hex nibbles) with a req/ack handshake. The granted value is held on the display for `HOLD_CYCLES` clocks, then the requester is acknowledged and the next requester is served. The block sits between the application logic and the `Segment_led` decoder: it drives `seg_data_1` and `seg_data_2`, and `seg_blank` gates the SEG enable bit.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of `active_id`; equals clog2(`N_REQ`).
- `HOLD_CYCLES`, default 12_000_000: display time per grant in clocks (1 s at 12 MHz); must be ≥1.
- `CNT_W`, default 24: hold-counter width; must satisfy 2^`CNT_W` > `HOLD_CYCLES`.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, `N_REQ`: request per requester; held high until that requester's ack.
- `req_data`, in, 8*`N_REQ`: requester i occupies bits [8i+7:8i]; the high nibble goes to digit 1 and the low nibble to digit 2.
- `ack`, out, `N_REQ`: one-cycle pulse on the served requester's bit when its slot ends.
- `seg_data_1`, out, 4: nibble for digit 1.
- `seg_data_2`, out, 4: nibble for digit 2.
- `seg_blank`, out, 1: 1 = display off, no owner.
- `active_id`, out, `ID_W`: index of the current owner; valid while `busy`.
- `busy`, out, 1: high in SHOW and ACK.

## Operation
- FSM states are IDLE, SHOW and ACK. All outputs are registered.
- **IDLE:** `seg_blank`=1 and `busy`=0.
  - If any `req` bit is set, the arbiter picks the first set bit searching upward from `last_id+1`, wrapping modulo `N_REQ`.
  - On a pick: latch that requester's byte into `seg_data_1`/`seg_data_2`, set `active_id`, clear the counter, and go to SHOW.
- **SHOW:** `seg_blank`=0 and `busy`=1.
  - The counter increments each cycle.
  - When the counter reaches `HOLD_CYCLES`-1, go to ACK.
  - `req`/`req_data` changes are ignored; the data was latched at grant.
- **ACK:** `ack[active_id]`=1 for exactly this cycle. Set `last_id`=`active_id`, then go to IDLE.
  - Display data and `seg_blank`=0 are held through ACK.
  - In IDLE, `seg_blank` returns to 1 and data holds its last value.
- **Fairness:** `last_id` resets to `N_REQ`-1, so requester 0 wins the first arbitration. A requester just served has the lowest priority next time.
- **Requester contract:**
  - Sample `ack` at a rising edge and drop `req` at that same edge, so IDLE never sees a stale request.
  - A requester that keeps `req` high after ack is treated as a new request and is served again in round-robin order.
- **Request withdrawn before grant:** no effect. Only the value of `req` in IDLE matters.
- **Reset:** `rst` at any state, including mid-SHOW, forces IDLE on the next edge. No ack is issued for the aborted slot.
- **Reset values:** `seg_data_1`=0, `seg_data_2`=0, `seg_blank`=1, `ack`=0, `busy`=0, `active_id`=0, counter=0, `last_id`=`N_REQ`-1.

## Timing
- Cycle t: IDLE with `req[i]`=1.
- t+1: SHOW; data visible; `busy`=1.
- Cycles t+1 .. t+`HOLD_CYCLES` are SHOW, i.e. exactly `HOLD_CYCLES` cycles of display.
- t+`HOLD_CYCLES`+1: ACK, `ack[i]`=1.
- t+`HOLD_CYCLES`+2: IDLE.
- Minimum grant-to-grant period is `HOLD_CYCLES`+2 cycles.
- With `HOLD_CYCLES`=1: one SHOW cycle, then ACK.
- `ack` is never asserted on more than one bit, and never in IDLE or SHOW.

## Structure
- Shared package `seg_pkg` holds:
  - FSM state enum `seg_sched_state_t` (IDLE/SHOW/ACK, 2-bit);
  - the default `HOLD_CYCLES`;
  - the nibble-slice helper constants: digit-1 high nibble, digit-2 low nibble.
- One sub-module, `rr_arbiter`: combinational round-robin pick. Inputs are `req` and `last_id`; outputs are `grant_valid` and `grant_id`. The FSM, counter and output registers stay in `seg_display_sched`.
- Target size: about 200 RTL lines.

## Test plan
Run with `N_REQ`=4 and `HOLD_CYCLES`=4.
- **Reset values:** after reset, `seg_blank`=1, `busy`=0, `ack`=0 and `seg_data`=0/0.
- **Single request:** `req`=0001 with byte 0x3A.
  - Next cycle: `seg_data_1`=3, `seg_data_2`=A, `seg_blank`=0.
  - 4 SHOW cycles, then `ack`=0001 for 1 cycle, then blank.
- **All four requesting:** `req`=1111 with bytes 0x11/0x22/0x33/0x44, each requester dropping `req` on its ack.
  - Grants run in order 0,1,2,3, each lasting 6 cycles grant-to-grant.
  - Exactly 4 ack pulses.
- **Re-request fairness:** `req`=0011 and requester 0 re-raises `req` immediately after its ack.
  - Order is 0,1,0,1; requester 1 is never starved.
- **Late change ignored:** change `req_data`[7:0] from 0x5C to 0x99 mid-SHOW.
  - Display stays 5/C until ACK.
- **Reset mid-operation:** assert `rst` on the 2nd SHOW cycle.
  - Next edge: IDLE, `seg_blank`=1, no ack.
  - After release with `req`=0001 held: requester 0 is re-granted first.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display scheduler:
//   - seg_sched_state_t : scheduler FSM state encoding (IDLE / SHOW / ACK)
//   - HOLD_CYCLES_DEFAULT: default display time per grant (1 s at 12 MHz)
//   - DIG1_LSB / DIG2_LSB: where each digit's nibble sits inside a request byte
//   - nibble()          : extracts one 4-bit digit from a request byte
// -----------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_ACK  = 2'd2
  } seg_sched_state_t;

  localparam int HOLD_CYCLES_DEFAULT = 32'd12_000_000;

  // Digit 1 shows the high nibble, digit 2 the low nibble.
  localparam int DIG1_LSB = 32'd4;
  localparam int DIG2_LSB = 32'd0;

  function automatic logic [3:0] nibble(input logic [7:0] b, input int lsb);
    logic [7:0] sh;
    sh = b >> lsb;
    return sh[3:0];
  endfunction

endpackage

// File: rtl/seg_display_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches upward from last_id+1, wrapping
// modulo N_REQ, and returns the first requester whose req bit is set.
// Ports:
//   req         in  N_REQ : request vector
//   last_id     in  ID_W  : requester served most recently
//   grant_valid out 1     : some request is pending
//   grant_id    out ID_W  : chosen requester (valid with grant_valid)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id
);

  int              sum_s;
  logic [ID_W-1:0] idx_s;
  logic [ID_W-1:0] grant_id_s;

  // Walk candidates from farthest to nearest so the nearest set bit after
  // last_id is the one left standing in grant_id_s.
  always_comb begin
    sum_s      = 0;
    idx_s      = '0;
    grant_id_s = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      sum_s      = int'(last_id) + k;
      idx_s      = ID_W'(sum_s % N_REQ);
      grant_id_s = req[idx_s] ? idx_s : grant_id_s;
    end
  end

  assign grant_valid = |req;
  assign grant_id    = grant_id_s;

endmodule

// File: rtl/seg_display_sched.sv
// -----------------------------------------------------------------------------
// seg_display_sched
// Time-shares the two-digit seven-segment display between N_REQ requesters.
// A granted byte is shown for HOLD_CYCLES clocks, then the owner gets a
// one-cycle ack and the next requester (round robin) is served.
// Ports:
//   clk        in  1        : system clock
//   rst        in  1        : synchronous active-high reset
//   req        in  N_REQ    : request per requester, held until its ack
//   req_data   in  8*N_REQ  : byte per requester, requester i at [8i+7:8i]
//   ack        out N_REQ    : one-cycle pulse on the served requester's bit
//   seg_data_1 out 4        : digit 1 nibble (high nibble of the byte)
//   seg_data_2 out 4        : digit 2 nibble (low nibble of the byte)
//   seg_blank  out 1        : 1 = display off, no owner
//   active_id  out ID_W     : current owner, valid while busy
//   busy       out 1        : high in SHOW and ACK
// -----------------------------------------------------------------------------
module seg_display_sched
  import seg_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int CNT_W       = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic [3:0]           seg_data_1,
  output logic [3:0]           seg_data_2,
  output logic                 seg_blank,
  output logic [ID_W-1:0]      active_id,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [N_REQ-1:0] ACK_ONE   = N_REQ'(1);
  localparam logic [ID_W-1:0]  LAST_RST  = ID_W'(N_REQ - 1);

  seg_sched_state_t  state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ID_W-1:0]   last_id_q;
  logic [ID_W-1:0]   id_q;
  logic [N_REQ-1:0]  ack_q;
  logic [3:0]        dig1_q;
  logic [3:0]        dig2_q;
  logic              blank_q;
  logic              busy_q;

  logic              grant_valid_s;
  logic [ID_W-1:0]   grant_id_s;
  logic [7:0]        grant_byte_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req         (req),
    .last_id     (last_id_q),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Byte of the requester the arbiter would grant this cycle.
  assign grant_byte_s = req_data[{grant_id_s, 3'b000} +: 8];

  // Scheduler FSM with hold counter and registered display/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_id_q <= LAST_RST;
      id_q      <= '0;
      ack_q     <= '0;
      dig1_q    <= 4'h0;
      dig2_q    <= 4'h0;
      blank_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= '0;
          if (grant_valid_s) begin
            state_q <= ST_SHOW;
            dig1_q  <= nibble(grant_byte_s, DIG1_LSB);
            dig2_q  <= nibble(grant_byte_s, DIG2_LSB);
            id_q    <= grant_id_s;
            cnt_q   <= '0;
            blank_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            blank_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_SHOW: begin
          // The counter reaching HOLD_LAST marks the last SHOW cycle.
          if (cnt_q == HOLD_LAST) begin
            state_q <= ST_ACK;
            ack_q   <= ACK_ONE << id_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_ACK: begin
          ack_q     <= '0;
          last_id_q <= id_q;
          blank_q   <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= '0;
          blank_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign seg_data_1 = dig1_q;
  assign seg_data_2 = dig2_q;
  assign seg_blank  = blank_q;
  assign active_id  = id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seg_display_sched.sv
// -----------------------------------------------------------------------------
// tb_seg_display_sched
// Self-checking bench for seg_display_sched (N_REQ=4, HOLD_CYCLES=4).
// A slot-level reference model inside the driver decides, from the requests
// the bench itself presents, who is granted and when, and pushes the expected
// ack into a scoreboard; a negedge monitor pops and compares on every ack and
// checks busy/blank/display against the model's timeline every cycle.
// -----------------------------------------------------------------------------
module tb_seg_display_sched;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int H   = 4;
  localparam int CW  = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     ack;
  logic [3:0]       seg_data_1;
  logic [3:0]       seg_data_2;
  logic             seg_blank;
  logic [IDW-1:0]   active_id;
  logic             busy;

  seg_display_sched #(
    .N_REQ       (N),
    .ID_W        (IDW),
    .HOLD_CYCLES (H),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .seg_data_1 (seg_data_1),
    .seg_data_2 (seg_data_2),
    .seg_blank  (seg_blank),
    .active_id  (active_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         ack_cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         order_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         ack_seen = 0;
  bit         mon_en   = 1'b0;

  // Reference model state (slot timeline).
  int         m_last;
  int         m_free;
  int         m_grant;
  int         m_ack;
  int         m_owner;
  logic [7:0] m_data;
  bit         m_slot  = 1'b0;
  bit         m_flush = 1'b0;

  // Requester behaviour.
  bit         pend[N];
  logic [7:0] dat[N];
  int         rereq_left[N];
  int         p_new = 0, p_wd = 0, p_mut = 0, p_rr = 0;
  bit         rst_v = 1'b1;

  // Expected observable outputs for the current cycle.
  logic         exp_busy = 1'b0;
  logic [N-1:0] exp_ack  = '0;
  logic [7:0]   exp_data = 8'h00;
  int           exp_id   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle of stimulus plus the reference model's decision for it.
  task automatic step();
    int  id;
    bit  found;
    @(posedge clk);
    #1;
    cyc++;
    if (m_flush) begin
      sb_q.delete();
      m_flush = 1'b0;
    end
    // Owner sampled its ack at the edge just passed: drop or re-raise req.
    if (m_slot && m_ack == cyc - 1) begin
      if (rereq_left[m_owner] > 0) begin
        rereq_left[m_owner]--;
        dat[m_owner] = 8'($urandom);
      end else if (p_rr > 0 && $urandom_range(99) < p_rr) begin
        dat[m_owner] = 8'($urandom);
      end else begin
        pend[m_owner] = 1'b0;
      end
      m_slot = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_slot && m_owner == i) begin
        if (p_mut > 0 && $urandom_range(99) < p_mut) dat[i] = 8'($urandom);
      end else if (!pend[i] && p_new > 0 && $urandom_range(99) < p_new) begin
        pend[i] = 1'b1;
        dat[i]  = 8'($urandom);
      end else if (pend[i] && p_wd > 0 && $urandom_range(99) < p_wd) begin
        pend[i] = 1'b0;
      end
    end
    rst = rst_v;
    for (int i = 0; i < N; i++) begin
      req[i]            = pend[i];
      req_data[8*i +: 8] = dat[i];
    end
    // Outputs visible in this cycle.
    exp_busy = 1'b0;
    exp_ack  = '0;
    if (m_slot) begin
      exp_busy = (cyc > m_grant);
      exp_data = m_data;
      exp_id   = m_owner;
      if (cyc == m_ack) exp_ack[m_owner] = 1'b1;
    end
    // Decision taken at the edge that ends this cycle.
    if (rst_v) begin
      m_flush = 1'b1;
      m_slot  = 1'b0;
      m_last  = N - 1;
      m_free  = cyc + 1;
    end else if (cyc == m_free) begin
      found = 1'b0;
      id    = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && pend[(m_last + k) % N]) begin
          found = 1'b1;
          id    = (m_last + k) % N;
        end
      end
      if (found) begin
        m_slot  = 1'b1;
        m_owner = id;
        m_data  = dat[id];
        m_grant = cyc;
        m_ack   = cyc + H + 1;
        m_free  = cyc + H + 2;
        m_last  = id;
        sb_q.push_back('{id: id, data: dat[id], ack_cyc: cyc + H + 1});
      end else begin
        m_free = cyc + 1;
      end
    end
  endtask

  task automatic apply_reset();
    rst_v = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    rst_v = 1'b0;
    for (int i = 0; i < N; i++) rereq_left[i] = 0;
    order_q.delete();
    ack_seen = 0;
  endtask

  // Monitor: per-cycle timeline checks and scoreboard pop on each ack.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("seg_blank", 32'(seg_blank), 32'(!exp_busy));
      check("ack", 32'(ack), 32'(exp_ack));
      if (exp_busy) begin
        check("digit1", 32'(seg_data_1), 32'(exp_data[7:4]));
        check("digit2", 32'(seg_data_2), 32'(exp_data[3:0]));
        check("active_id", 32'(active_id), 32'(exp_id));
      end
      if (ack != '0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_ack: got 0x%0h, expected no ack (cycle %0d)", ack, cyc);
        end else begin
          e = sb_q.pop_front();
          check("ack_vector", 32'(ack), 32'(1) << e.id);
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          check("ack_display", 32'({seg_data_1, seg_data_2}), 32'(e.data));
          order_q.push_back(e.id);
          ack_seen++;
        end
      end
    end
  end

  initial begin
    int exp_ord[4];
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    m_last   = N - 1;
    m_free   = 0;
    for (int i = 0; i < N; i++) begin
      pend[i]       = 1'b0;
      dat[i]        = 8'h00;
      rereq_left[i] = 0;
    end

    // Reset values.
    apply_reset();
    check("rst_seg_data_1", 32'(seg_data_1), 32'h0);
    check("rst_seg_data_2", 32'(seg_data_2), 32'h0);
    check("rst_seg_blank", 32'(seg_blank), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_active_id", 32'(active_id), 32'h0);

    // Single request 0x3A from requester 0.
    pend[0] = 1'b1;
    dat[0]  = 8'h3A;
    repeat (12) step();
    check("single_ack_count", 32'(ack_seen), 32'd1);

    // All four requesting: grants 0,1,2,3, six cycles apart.
    apply_reset();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      dat[i]  = 8'(8'h11 * (i + 1));
    end
    repeat (30) step();
    check("all4_ack_count", 32'(ack_seen), 32'd4);
    exp_ord = '{0, 1, 2, 3};
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      check("all4_order", 32'(order_q[i]), 32'(exp_ord[i]));

    // Re-request fairness: both re-raise once, order must interleave.
    apply_reset();
    pend[0] = 1'b1; dat[0] = 8'hA0;
    pend[1] = 1'b1; dat[1] = 8'hB1;
    rereq_left[0] = 1;
    rereq_left[1] = 1;
    repeat (30) step();
    check("fair_ack_count", 32'(ack_seen), 32'd4);
    exp_ord = '{0, 1, 0, 1};
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      check("fair_order", 32'(order_q[i]), 32'(exp_ord[i]));

    // Late data change mid-SHOW must not reach the display.
    apply_reset();
    pend[0] = 1'b1;
    dat[0]  = 8'h5C;
    step();            // grant decision
    step();            // SHOW 1
    step();            // SHOW 2
    dat[0]  = 8'h99;   // presented from SHOW 3 onward
    repeat (8) step();
    check("late_ack_count", 32'(ack_seen), 32'd1);

    // Reset on the second SHOW cycle: no ack, then requester 0 re-granted.
    apply_reset();
    pend[0] = 1'b1;
    dat[0]  = 8'h7E;
    step();            // grant decision
    step();            // SHOW 1
    rst_v = 1'b1;
    step();            // SHOW 2 with rst asserted
    rst_v = 1'b0;
    step();            // back in IDLE
    check("midrst_blank", 32'(seg_blank), 32'h1);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_ack", 32'(ack), 32'h0);
    repeat (10) step();
    check("midrst_ack_count", 32'(ack_seen), 32'd1);
    if (order_q.size() > 0) check("midrst_regrant_id", 32'(order_q[0]), 32'd0);

    // Randomized traffic with withdrawals, re-requests and data churn.
    apply_reset();
    p_new = 30; p_wd = 5; p_mut = 20; p_rr = 25;
    repeat (3000) step();
    p_new = 0; p_wd = 0; p_rr = 0;
    repeat (60) step();
    check("drain_scoreboard", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
